// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// risc_pkg : shared RISC-V encodings and redirect-controller types  (rev 1.0)
// ============================================================================
package risc_pkg;

   localparam int CNT_W_DEFAULT = 16;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } brc_state_e;

endpackage
`default_nettype wire

// File: rtl/branch_control.sv
`default_nettype none
// ============================================================================
// branch_control : evaluates B-type branch condition from funct3  (rev 1.0)
// ============================================================================
module branch_control
   import risc_pkg::*;
(
   input  logic        i_is_b_type,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_opr_a,
   input  logic [31:0] i_opr_b,
   output logic        o_taken
);

   logic w_eq;
   logic w_lt_s;
   logic w_lt_u;
   logic w_cond;

   assign w_eq   = (i_opr_a == i_opr_b);
   assign w_lt_s = ($signed(i_opr_a) < $signed(i_opr_b));
   assign w_lt_u = (i_opr_a < i_opr_b);

   always_comb begin
      w_cond = 1'b0;
      case (i_funct3)
         F3_BEQ:  w_cond = w_eq;
         F3_BNE:  w_cond = ~w_eq;
         F3_BLT:  w_cond = w_lt_s;
         F3_BGE:  w_cond = ~w_lt_s;
         F3_BLTU: w_cond = w_lt_u;
         F3_BGEU: w_cond = ~w_lt_u;
         default: w_cond = 1'b0;
      endcase
   end

   assign o_taken = i_is_b_type & w_cond;

endmodule
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// branch_redirect_ctrl : EX-stage mispredict detection, flush and redirect  (rev 1.0)
// ============================================================================
module branch_redirect_ctrl
   import risc_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = CNT_W_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic [31:0]      ex_pc,
   input  logic [31:0]      ex_imm,
   input  logic [31:0]      opr_a,
   input  logic [31:0]      opr_b,
   input  logic             is_b_type,
   input  logic             is_jal,
   input  logic             is_jalr,
   input  logic [2:0]       funct3,
   input  logic             pred_taken,
   input  logic             redirect_ready,
   output logic             ex_stall,
   output logic             flush_if_id,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   brc_state_e       r_state;
   brc_state_e       w_state_nxt;
   logic [3:0]       r_flush_cnt;
   logic [31:0]      r_redirect_pc;
   logic [CNT_W-1:0] r_branch_cnt;
   logic [CNT_W-1:0] r_mispredict_cnt;

   logic        w_bc_taken;
   logic        w_taken;
   logic        w_is_ctl;
   logic        w_mispredict;
   logic        w_idle;
   logic [31:0] w_jalr_sum;
   logic [31:0] w_target;
   logic        w_flush;
   logic        w_stall;
   logic        w_rvalid;

   branch_control u_branch_control (
      .i_is_b_type (is_b_type),
      .i_funct3    (funct3),
      .i_opr_a     (opr_a),
      .i_opr_b     (opr_b),
      .o_taken     (w_bc_taken)
   );

   assign w_idle       = (r_state == ST_IDLE);
   assign w_is_ctl     = is_b_type | is_jal | is_jalr;
   assign w_taken      = is_b_type ? w_bc_taken : (is_jal | is_jalr);
   assign w_mispredict = ex_valid &
                         ((((is_b_type | is_jal) & (w_taken != pred_taken))) | is_jalr);
   assign w_jalr_sum   = opr_a + ex_imm;

   always_comb begin
      w_target = ex_pc + 32'd4;
      if (is_jalr)
         w_target = {w_jalr_sum[31:1], 1'b0};
      else if (w_taken)
         w_target = ex_pc + ex_imm;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:     if (w_mispredict)       w_state_nxt = ST_FLUSH;
         ST_FLUSH:    if (r_flush_cnt == 4'd0) w_state_nxt = ST_REDIRECT;
         ST_REDIRECT: if (redirect_ready)     w_state_nxt = ST_IDLE;
         default:                             w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded purely from the state register
   always_comb begin
      w_flush  = 1'b0;
      w_stall  = 1'b0;
      w_rvalid = 1'b0;
      case (r_state)
         ST_FLUSH: begin
            w_flush = 1'b1;
            w_stall = 1'b1;
         end
         ST_REDIRECT: begin
            w_rvalid = 1'b1;
            w_stall  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_flush_cnt      <= 4'd0;
         r_redirect_pc    <= 32'd0;
         r_branch_cnt     <= '0;
         r_mispredict_cnt <= '0;
      end else begin
         if (w_idle && w_mispredict) begin
            r_flush_cnt   <= c_FLUSH_LOAD;
            r_redirect_pc <= w_target;
         end else if (r_state == ST_FLUSH && r_flush_cnt != 4'd0) begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
         end
         if (w_idle && ex_valid && w_is_ctl && !(&r_branch_cnt))
            r_branch_cnt <= r_branch_cnt + 1'b1;
         if (w_idle && w_mispredict && !(&r_mispredict_cnt))
            r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
      end
   end

   assign ex_stall       = w_stall;
   assign flush_if_id    = w_flush;
   assign redirect_valid = w_rvalid;
   assign redirect_pc    = r_redirect_pc;
   assign branch_cnt     = r_branch_cnt;
   assign mispredict_cnt = r_mispredict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// tb_branch_redirect_ctrl : directed + random check against a behavioural model  (rev 1.0)
// ============================================================================
module tb_branch_redirect_ctrl;

   localparam int FLUSH = 2;
   localparam int TB_CNT_W = 4;
   localparam int CMAX = (1 << TB_CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n;
   logic ex_valid;
   logic [31:0] ex_pc, ex_imm, opr_a, opr_b;
   logic is_b_type, is_jal, is_jalr;
   logic [2:0] funct3;
   logic pred_taken, redirect_ready;
   logic ex_stall, flush_if_id, redirect_valid;
   logic [31:0] redirect_pc;
   logic [TB_CNT_W-1:0] branch_cnt, mispredict_cnt;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: remaining flush cycles, pending redirect, captured target, counts
   int m_flush_left = 0;
   bit m_redir = 0;
   logic [31:0] m_pc = 32'd0;
   int m_bc = 0;
   int m_mc = 0;

   branch_redirect_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(TB_CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .opr_a(opr_a), .opr_b(opr_b), .is_b_type(is_b_type), .is_jal(is_jal),
      .is_jalr(is_jalr), .funct3(funct3), .pred_taken(pred_taken),
      .redirect_ready(redirect_ready), .ex_stall(ex_stall), .flush_if_id(flush_if_id),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit cond_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_update();
      bit taken, misp, ctl;
      logic [31:0] jsum;
      if (!rst_n) begin
         m_flush_left = 0; m_redir = 0; m_pc = 32'd0; m_bc = 0; m_mc = 0;
      end else if (m_flush_left > 0) begin
         m_flush_left--;
         if (m_flush_left == 0) m_redir = 1;
      end else if (m_redir) begin
         if (redirect_ready) m_redir = 0;
      end else if (ex_valid) begin
         ctl   = is_b_type || is_jal || is_jalr;
         taken = is_b_type ? cond_taken(funct3, opr_a, opr_b) : (is_jal || is_jalr);
         misp  = ((is_b_type || is_jal) && (taken != pred_taken)) || is_jalr;
         if (ctl && m_bc < CMAX) m_bc++;
         if (misp) begin
            if (m_mc < CMAX) m_mc++;
            jsum = opr_a + ex_imm;
            m_pc = is_jalr ? (jsum & ~32'd1) : (taken ? ex_pc + ex_imm : ex_pc + 32'd4);
            m_flush_left = FLUSH;
         end
      end
   endtask

   task automatic compare_all();
      chk("flush", {31'd0, flush_if_id}, {31'd0, m_flush_left > 0});
      chk("stall", {31'd0, ex_stall}, {31'd0, (m_flush_left > 0) || m_redir});
      chk("rvalid", {31'd0, redirect_valid}, {31'd0, m_redir});
      chk("rpc", redirect_pc, m_pc);
      chk("bcnt", {28'd0, branch_cnt}, 32'(m_bc));
      chk("mcnt", {28'd0, mispredict_cnt}, 32'(m_mc));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic clear_ins();
      ex_valid = 0; ex_pc = 0; ex_imm = 0; opr_a = 0; opr_b = 0;
      is_b_type = 0; is_jal = 0; is_jalr = 0; funct3 = 0; pred_taken = 0;
      redirect_ready = 1;
   endtask

   task automatic do_reset();
      clear_ins();
      rst_n = 0;
      step();
      rst_n = 1;
   endtask

   task automatic drain();
      redirect_ready = 1;
      ex_valid = 0;
      for (int i = 0; i < 40 && (m_flush_left > 0 || m_redir); i++) step();
      chk("drain_idle", {31'd0, ex_stall}, 32'd0);
   endtask

   initial begin
      clear_ins();
      rst_n = 0;
      @(negedge clk);
      step();
      chk("rst_stall", {31'd0, ex_stall}, 32'd0);
      chk("rst_pc", redirect_pc, 32'd0);
      rst_n = 1;

      // BEQ taken, predicted not taken
      ex_valid = 1; is_b_type = 1; funct3 = 3'd0; opr_a = 5; opr_b = 5;
      pred_taken = 0; ex_pc = 32'h100; ex_imm = 32'h20; redirect_ready = 0;
      step();
      ex_valid = 0;
      chk("beq_flush1", {31'd0, flush_if_id}, 32'd1);
      step();
      chk("beq_flush2", {31'd0, flush_if_id}, 32'd1);
      step();
      chk("beq_rvalid", {31'd0, redirect_valid}, 32'd1);
      chk("beq_pc", redirect_pc, 32'h120);
      chk("beq_mcnt", {28'd0, mispredict_cnt}, 32'd1);
      chk("beq_bcnt", {28'd0, branch_cnt}, 32'd1);
      redirect_ready = 1;
      step();
      chk("beq_idle", {31'd0, ex_stall}, 32'd0);

      // BLT correctly predicted taken
      clear_ins();
      ex_valid = 1; is_b_type = 1; funct3 = 3'd4; opr_a = 32'hFFFF_FFFF; opr_b = 1; pred_taken = 1;
      step();
      ex_valid = 0;
      chk("blt_stall", {31'd0, ex_stall}, 32'd0);
      chk("blt_bcnt", {28'd0, branch_cnt}, 32'd2);
      chk("blt_mcnt", {28'd0, mispredict_cnt}, 32'd1);

      // JALR with delayed ready
      clear_ins();
      ex_valid = 1; is_jalr = 1; opr_a = 32'h2001; ex_imm = 32'h4; pred_taken = 1; redirect_ready = 0;
      step();
      ex_valid = 0;
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("jalr_hold_v", {31'd0, redirect_valid}, 32'd1);
         chk("jalr_hold_pc", redirect_pc, 32'h2004);
      end
      redirect_ready = 1;
      step();
      chk("jalr_idle", {31'd0, redirect_valid}, 32'd0);

      // BGEU not taken, predicted taken, PC wrap
      clear_ins();
      ex_valid = 1; is_b_type = 1; funct3 = 3'd7; opr_a = 1; opr_b = 2; pred_taken = 1;
      ex_pc = 32'hFFFF_FFFC; ex_imm = 32'h40;
      step();
      drain();
      chk("bgeu_wrap", redirect_pc, 32'h0);

      // Reset in second flush cycle
      clear_ins();
      ex_valid = 1; is_jal = 1; pred_taken = 0; ex_pc = 32'h500; ex_imm = 32'h10;
      step();
      ex_valid = 0;
      step();
      rst_n = 0;
      step();
      rst_n = 1;
      chk("rstf_flush", {31'd0, flush_if_id}, 32'd0);
      chk("rstf_bcnt", {28'd0, branch_cnt}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rstf_norv", {31'd0, redirect_valid}, 32'd0);
      end

      // Saturation: 20 mispredicting branches
      do_reset();
      for (int i = 0; i < 20; i++) begin
         clear_ins();
         ex_valid = 1; is_b_type = 1; funct3 = 3'd1; opr_a = 1; opr_b = 2; pred_taken = 0;
         ex_pc = 32'(i * 16); ex_imm = 32'h8;
         step();
         drain();
      end
      chk("sat_bcnt", {28'd0, branch_cnt}, 32'hF);
      chk("sat_mcnt", {28'd0, mispredict_cnt}, 32'hF);

      // Random phase
      do_reset();
      for (int i = 0; i < 600; i++) begin
         int cls;
         ex_valid = ($urandom % 4) != 0;
         cls = $urandom % 5;
         is_b_type = (cls == 0); is_jal = (cls == 1); is_jalr = (cls == 2);
         funct3 = 3'($urandom);
         opr_a = $urandom;
         opr_b = (($urandom % 4) == 0) ? opr_a : $urandom;
         ex_pc = $urandom; ex_imm = $urandom;
         pred_taken = 1'($urandom);
         redirect_ready = ($urandom % 3) != 0;
         rst_n = ($urandom % 60) != 0;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: cycles flush_if_id is held per redirect; legal range 1..15.
REQ-002 Parameter CNT_W, default 16: width of the statistics counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 ex_valid  input  1  EX stage holds a valid instruction this cycle.
REQ-006 ex_pc  input  32  PC of the EX instruction.
REQ-007 ex_imm  input  32  sign-extended immediate of the EX instruction.
REQ-008 opr_a, opr_b  input  32 each  comparison operands; opr_a is also the JALR base.
REQ-009 is_b_type, is_jal, is_jalr  input  1 each  instruction class; at most one is high.
REQ-010 funct3  input  3  branch condition encoding.
REQ-011 pred_taken  input  1  fetch-time prediction for this instruction.
REQ-012 redirect_ready  input  1  fetch accepts the redirect PC.
REQ-013 ex_stall  output  1  holds EX/ID/IF while a redirect is in progress.
REQ-014 flush_if_id  output  1  kills IF and ID stage contents.
REQ-015 redirect_valid  output  1  redirect_pc is valid.
REQ-016 redirect_pc  output  32  corrected fetch address.
REQ-017 branch_cnt, mispredict_cnt  output  CNT_W each  resolved control-transfer count and redirect count.

Function
REQ-018 Actual outcome: B-type taken per branch_control condition; JAL and JALR always taken; other instructions not taken.
REQ-019 Mispredict: ex_valid and (B-type or JAL) and taken != pred_taken; or ex_valid and JALR (always redirects).
REQ-020 Target: taken B/JAL = ex_pc+ex_imm; JALR = (opr_a+ex_imm) with bit 0 cleared; mispredicted not-taken = ex_pc+4; all sums mod 2^32.
REQ-021 FSM states: IDLE, FLUSH, REDIRECT; encoding is free.
REQ-022 IDLE: on mispredict, capture target into redirect_pc, load flush counter with FLUSH_CYCLES-1, go to FLUSH next cycle; otherwise stay in IDLE.
REQ-023 FLUSH: flush_if_id=1 and ex_stall=1; decrement counter; when counter is 0, go to REDIRECT.
REQ-024 REDIRECT: redirect_valid=1 and ex_stall=1; redirect_pc stays stable; when redirect_ready=1, go to IDLE next cycle.
REQ-025 redirect_ready while redirect_valid=0 has no effect.
REQ-026 Latency: mispredict in cycle N gives flush_if_id high in cycles N+1..N+FLUSH_CYCLES and redirect_valid from cycle N+FLUSH_CYCLES+1.
REQ-027 ex_valid in FLUSH or REDIRECT is ignored (EX is stalled): no capture, no count.
REQ-028 branch_cnt increments by 1 per IDLE cycle with ex_valid and any of is_b_type/is_jal/is_jalr; mispredict_cnt increments by 1 per redirect started. Both saturate at all-ones.
REQ-029 All outputs come from registers or decode of the state register only; no combinational path from inputs to outputs.

Reset
REQ-030 rst_n=0 at a clock edge forces IDLE, flush counter 0, redirect_pc 0, both counters 0, and all 1-bit outputs 0, regardless of current state.
REQ-031 Reset during FLUSH or REDIRECT abandons the pending redirect; no redirect_valid follows after reset.

Structure
REQ-032 The state enum and the CNT_W default are in risc_pkg; funct3 branch encodings are reused from risc_pkg.
REQ-033 branch_control is instantiated as the one sub-module, fed with is_b_type; no other sub-modules.

Verification
REQ-034 BEQ, opr_a=opr_b=5, pred_taken=0, ex_pc=0x100, ex_imm=0x20 -> flush_if_id high 2 cycles, then redirect_valid with redirect_pc=0x120; mispredict_cnt=1, branch_cnt=1.
REQ-035 BLT, opr_a=0xFFFFFFFF, opr_b=1, pred_taken=1 -> no redirect, ex_stall stays 0, branch_cnt increments, mispredict_cnt unchanged.
REQ-036 JALR, opr_a=0x2001, ex_imm=0x4, redirect_ready held 0 for 3 cycles -> redirect_pc=0x2004, held stable with redirect_valid=1 until ready, then IDLE next cycle.
REQ-037 BGEU not taken, pred_taken=1, ex_pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap-around).
REQ-038 rst_n=0 in the second FLUSH cycle -> next cycle all outputs 0 and counters 0; no redirect_valid in the following 5 cycles.
REQ-039 Counter saturation with CNT_W=4: 20 mispredicting branches -> both counters stop at 0xF.
